// File: rtl/spike_window_classifier_pkg.sv
// Shared types and default sizing for the spike window classifier.
//   swc_state_e      : classifier FSM states
//   DEF_NUM_NEURONS  : default excitatory neuron count
//   DEF_WINDOW_STEPS : default time steps per presentation window
//   DEF_COUNT_WIDTH  : default per-neuron spike counter width
package spike_window_classifier_pkg;

    localparam int unsigned DEF_NUM_NEURONS  = 100;
    localparam int unsigned DEF_WINDOW_STEPS = 350;
    localparam int unsigned DEF_COUNT_WIDTH  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } swc_state_e;

endpackage

// File: rtl/sat_spike_counter.sv
// Single saturating spike counter.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : synchronous clear (wins over inc)
//   inc        : increment by one, holds at all-ones
//   count      : current count (registered)
module sat_spike_counter
    import spike_window_classifier_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_COUNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count up until all-ones, then hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/spike_window_classifier.sv
// Spike window classifier: counts excitatory spikes per neuron over one
// presentation window, then scans the counts sequentially for the argmax
// and offers {winner_idx, winner_count, no_spike} over a valid/ready handshake.
// Optional macro SPIKE_WINDOW_EARLY_STOP_EN: end the window as soon as any
// count reaches EARLY_STOP_COUNT and expose the early_stop status output.
//   clk, reset    : clock, asynchronous active-low reset
//   start         : opens a new window (sampled in IDLE only)
//   step_valid    : spikes_in carries one time step this cycle
//   spikes_in     : excitatory spike vector
//   busy          : not in IDLE
//   result_valid  : result available, held until result_ready
//   result_ready  : consumer accepts the result
//   winner_idx    : index of highest-count neuron (lowest index on ties)
//   winner_count  : count of the winner
//   early_stop    : window ended by the early-stop condition (macro only)
//   no_spike      : every count in the window was zero
module spike_window_classifier
    import spike_window_classifier_pkg::*;
#(
    parameter int unsigned NUM_NEURONS      = DEF_NUM_NEURONS,
    parameter int unsigned COUNT_WIDTH      = DEF_COUNT_WIDTH,
    parameter int unsigned WINDOW_STEPS     = DEF_WINDOW_STEPS,
    parameter int unsigned STEP_WIDTH       = 16,
    parameter int unsigned IDX_WIDTH        = 7,
    parameter int unsigned EARLY_STOP_COUNT = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   step_valid,
    input  logic [NUM_NEURONS-1:0] spikes_in,
    output logic                   busy,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [IDX_WIDTH-1:0]   winner_idx,
    output logic [COUNT_WIDTH-1:0] winner_count,
`ifdef SPIKE_WINDOW_EARLY_STOP_EN
    output logic                   early_stop,
`endif
    output logic                   no_spike
);

`ifdef SPIKE_WINDOW_EARLY_STOP_EN
    localparam bit EARLY_STOP_EN = 1'b1;
`else
    localparam bit EARLY_STOP_EN = 1'b0;
`endif

    // Early stop can only fire if the threshold is representable in a counter
    localparam bit ES_REACHABLE = (EARLY_STOP_COUNT >= 1) &&
                                  (EARLY_STOP_COUNT <= (2**COUNT_WIDTH - 1));
    localparam logic [COUNT_WIDTH-1:0] ES_PRE    = COUNT_WIDTH'(EARLY_STOP_COUNT - 1);
    localparam logic [STEP_WIDTH-1:0]  LAST_STEP = STEP_WIDTH'(WINDOW_STEPS - 1);
    localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(NUM_NEURONS - 1);

    swc_state_e              state;
    logic [STEP_WIDTH-1:0]   step_cnt;
    logic [IDX_WIDTH-1:0]    scan_idx;
    logic [IDX_WIDTH-1:0]    best_idx;
    logic [COUNT_WIDTH-1:0]  best_count;
    logic [COUNT_WIDTH-1:0]  counts [NUM_NEURONS];

    logic                    clear_c;
    logic [NUM_NEURONS-1:0]  inc_vec_c;
    logic                    last_step_c;
    logic                    early_hit_c;
    logic                    window_end_c;
    logic [COUNT_WIDTH-1:0]  scan_count_c;
    logic                    scan_gt_c;
    logic [IDX_WIDTH-1:0]    fin_idx_c;
    logic [COUNT_WIDTH-1:0]  fin_count_c;
    logic                    scan_last_c;

    // Counter control: clear on an accepted start, increment on accepted steps
    assign clear_c     = (state == ST_IDLE) && start;
    assign inc_vec_c   = ((state == ST_ACCUM) && step_valid) ? spikes_in : '0;
    assign last_step_c = (state == ST_ACCUM) && step_valid && (step_cnt == LAST_STEP);

    // A count reaches the threshold this cycle when it sits one below and increments
    always_comb begin
        early_hit_c = 1'b0;
        for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
            if (inc_vec_c[i] && (counts[i] == ES_PRE)) begin
                early_hit_c = 1'b1;
            end
        end
        if (!ES_REACHABLE) begin
            early_hit_c = 1'b0;
        end
    end

    assign window_end_c = last_step_c || (EARLY_STOP_EN && early_hit_c);

    // Per-neuron saturating counters
    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_cnt
        sat_spike_counter #(
            .WIDTH (COUNT_WIDTH)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (clear_c),
            .inc   (inc_vec_c[g]),
            .count (counts[g])
        );
    end

    // Argmax step: strict compare keeps the lowest index on ties
    assign scan_count_c = counts[scan_idx];
    assign scan_gt_c    = scan_count_c > best_count;
    assign fin_idx_c    = scan_gt_c ? scan_idx : best_idx;
    assign fin_count_c  = scan_gt_c ? scan_count_c : best_count;
    assign scan_last_c  = (scan_idx == LAST_IDX);

    // FSM, step counter, scan registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            step_cnt     <= '0;
            scan_idx     <= '0;
            best_idx     <= '0;
            best_count   <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            winner_idx   <= '0;
            winner_count <= '0;
            no_spike     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_ACCUM;
                        busy         <= 1'b1;
                        step_cnt     <= '0;
                        winner_idx   <= '0;
                        winner_count <= '0;
                        no_spike     <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (step_valid) begin
                        step_cnt <= step_cnt + STEP_WIDTH'(1);
                    end
                    if (window_end_c) begin
                        state      <= ST_SCAN;
                        scan_idx   <= '0;
                        best_idx   <= '0;
                        best_count <= '0;
                    end
                end
                ST_SCAN: begin
                    best_idx   <= fin_idx_c;
                    best_count <= fin_count_c;
                    scan_idx   <= scan_idx + IDX_WIDTH'(1);
                    if (scan_last_c) begin
                        state        <= ST_DONE;
                        result_valid <= 1'b1;
                        winner_idx   <= fin_idx_c;
                        winner_count <= fin_count_c;
                        no_spike     <= (fin_count_c == '0);
                    end
                end
                ST_DONE: begin
                    if (result_ready) begin
                        state        <= ST_IDLE;
                        busy         <= 1'b0;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    busy         <= 1'b0;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPIKE_WINDOW_EARLY_STOP_EN
    // Records why the window closed; held through DONE, cleared by start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            early_stop <= 1'b0;
        end else if (clear_c) begin
            early_stop <= 1'b0;
        end else if ((state == ST_ACCUM) && window_end_c) begin
            early_stop <= early_hit_c;
        end
    end
`endif

endmodule

// File: tb/tb_spike_window_classifier.sv
// Scoreboard bench for spike_window_classifier: a behavioural model computes
// the expected result of each window as steps are driven; results are popped
// and compared when the DUT raises result_valid.
module tb_spike_window_classifier;

    localparam int unsigned N   = 100;
    localparam int unsigned CW  = 3;
    localparam int unsigned W   = 8;
    localparam int unsigned SW  = 16;
    localparam int unsigned IW  = 7;
    localparam int unsigned ESC = 5;
    localparam int unsigned CMAX = (1 << CW) - 1;
`ifdef SPIKE_WINDOW_EARLY_STOP_EN
    localparam bit ES_EN = 1'b1;
`else
    localparam bit ES_EN = 1'b0;
`endif

    typedef struct {
        int unsigned idx;
        int unsigned cnt;
        bit          nospk;
        bit          early;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          start;
    logic          step_valid;
    logic [N-1:0]  spikes_in;
    logic          busy;
    logic          result_valid;
    logic          result_ready;
    logic [IW-1:0] winner_idx;
    logic [CW-1:0] winner_count;
    logic          no_spike;
    logic          early_stop;

    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    spike_window_classifier #(
        .NUM_NEURONS      (N),
        .COUNT_WIDTH      (CW),
        .WINDOW_STEPS     (W),
        .STEP_WIDTH       (SW),
        .IDX_WIDTH        (IW),
        .EARLY_STOP_COUNT (ESC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .step_valid   (step_valid),
        .spikes_in    (spikes_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .winner_idx   (winner_idx),
        .winner_count (winner_count),
`ifdef SPIKE_WINDOW_EARLY_STOP_EN
        .early_stop   (early_stop),
`endif
        .no_spike     (no_spike)
    );

`ifndef SPIKE_WINDOW_EARLY_STOP_EN
    assign early_stop = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full window: drive steps, model them, wait for and check the result
    task automatic run_window(input int mode, input bit stall, input bit hold);
        int unsigned  cnt [N];
        logic [N-1:0] vec;
        int unsigned  k;
        int unsigned  n;
        bit           done;
        bit           hit;
        exp_t         e;
        exp_t         r;

        foreach (cnt[i]) cnt[i] = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);

        k = 0;
        done = 1'b0;
        while (!done) begin
            vec = '0;
            case (mode)
                0: if (k < 4) vec[37] = 1'b1;
                1: begin
                    if (k == 0 || k == 2 || k == 4) begin
                        vec[12] = 1'b1;
                        vec[80] = 1'b1;
                    end
                    if (k == 1) vec[3] = 1'b1;
                end
                2: vec[5] = 1'b1;
                3: vec = '0;
                default: for (int i = 0; i < N; i++) vec[i] = ($urandom_range(7) == 0);
            endcase
            step_valid = 1'b1;
            spikes_in  = vec;
            tick();
            step_valid = 1'b0;
            spikes_in  = '1;
            hit = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (vec[i]) begin
                    if (cnt[i] < CMAX) cnt[i]++;
                    if (cnt[i] == ESC) hit = 1'b1;
                end
            end
            k++;
            if (k == W || (ES_EN && hit)) done = 1'b1;
            if (!done && stall) begin
                start = 1'b1;
                tick();
                tick();
                start = 1'b0;
            end
        end

        e.idx = 0;
        e.cnt = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (cnt[i] > e.cnt) begin
                e.idx = i;
                e.cnt = cnt[i];
            end
        end
        e.nospk = (e.cnt == 0);
        e.early = ES_EN && hit;
        sb.push_back(e);

        // Inputs must be ignored while scanning
        step_valid = 1'b1;
        spikes_in  = '1;
        n = 0;
        while (!result_valid && n < 400) begin
            tick();
            n++;
        end
        step_valid = 1'b0;
        spikes_in  = '0;
        check("result_latency", n, N);

        r = sb.pop_front();
        check("winner_idx", 32'(winner_idx), r.idx);
        check("winner_count", 32'(winner_count), r.cnt);
        check("no_spike", 32'(no_spike), 32'(r.nospk));
        check("busy_done", 32'(busy), 32'd1);
`ifdef SPIKE_WINDOW_EARLY_STOP_EN
        check("early_stop", 32'(early_stop), 32'(r.early));
`endif

        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                tick();
                check("hold_valid", 32'(result_valid), 32'd1);
                check("hold_idx", 32'(winner_idx), r.idx);
                check("hold_count", 32'(winner_count), r.cnt);
            end
        end

        // Handshake with a coincident start, which must be ignored
        result_ready = 1'b1;
        start = 1'b1;
        tick();
        result_ready = 1'b0;
        start = 1'b0;
        check("valid_after_xfer", 32'(result_valid), 32'd0);
        check("busy_after_xfer", 32'(busy), 32'd0);
        check("idx_held", 32'(winner_idx), r.idx);
        tick();
        check("start_ignored", 32'(busy), 32'd0);
    endtask

    // Assert reset mid-operation asynchronously and check immediate abort
    task automatic async_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_idx"}, 32'(winner_idx), 32'd0);
        #2;
        reset = 1'b1;
        step_valid = 1'b0;
        spikes_in  = '0;
        tick();
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b0;
        start        = 1'b0;
        step_valid   = 1'b0;
        spikes_in    = '0;
        result_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        check("rst_idx", 32'(winner_idx), 32'd0);
        check("rst_count", 32'(winner_count), 32'd0);
        check("rst_nospk", 32'(no_spike), 32'd0);
        reset = 1'b1;
        tick();

        // step_valid in IDLE must not start anything
        step_valid = 1'b1;
        spikes_in  = '1;
        tick();
        step_valid = 1'b0;
        spikes_in  = '0;
        check("idle_ignore", 32'(busy), 32'd0);

        run_window(0, 1'b0, 1'b0);  // single neuron 37
        run_window(1, 1'b1, 1'b1);  // tie, stalls, backpressure
        run_window(2, 1'b0, 1'b0);  // saturation (or early stop)
        run_window(3, 1'b0, 1'b0);  // empty window

        // Reset during step 2 of ACCUM
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            step_valid = 1'b1;
            spikes_in  = '0;
            spikes_in[50] = 1'b1;
            tick();
        end
        step_valid = 1'b1;
        async_reset("rst_accum");

        // Reset during SCAN
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int s = 0; s < int'(W); s++) begin
            step_valid = 1'b1;
            spikes_in  = '0;
            spikes_in[60] = (s < 3);
            tick();
        end
        step_valid = 1'b0;
        spikes_in  = '0;
        for (int c = 0; c < 10; c++) tick();
        check("scan_busy_pre", 32'(busy), 32'd1);
        async_reset("rst_scan");

        run_window(0, 1'b0, 1'b0);  // clean result after reset
        for (int r = 0; r < 3; r++) run_window(4, r[0], 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
